// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller and the CPU control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package interrupt_controller_pkg;

    // Default sizing. The CPU control unit decodes irq_mode using the same
    // values, so change them here rather than at an instantiation.
    localparam int INTC_N_SRC  = 4;
    localparam int INTC_MODE_W = 3;

    // FSM state codes; 2'd3 is illegal and recovers to IDLE.
    localparam logic [1:0] INTC_IDLE = 2'd0;
    localparam logic [1:0] INTC_REQ  = 2'd1;
    localparam logic [1:0] INTC_SVC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = INTC_IDLE,
        ST_REQ  = INTC_REQ,
        ST_SVC  = INTC_SVC
    } intc_state_t;

    // Width of a source index, kept at least one bit wide.
    function automatic int intc_id_w(input int n_src);
        return (n_src > 1) ? $clog2(n_src) : 1;
    endfunction

endpackage

// File: rtl/int_priority_pick.sv
// Fixed-priority picker: lowest set index of elig wins, with its mode slice.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   elig     in   N_SRC          eligible (pending and unmasked) sources
//   mode_bus in   N_SRC*MODE_W   per-source mode codes
//   any      out  1              at least one source eligible
//   id       out  ID_W           index of the winning source (0 if none)
//   mode     out  MODE_W         mode of the winning source (0 if none)
module int_priority_pick
    import interrupt_controller_pkg::*;
#(
    parameter int N_SRC  = INTC_N_SRC,
    parameter int MODE_W = INTC_MODE_W,
    parameter int ID_W   = intc_id_w(INTC_N_SRC)
) (
    input  logic [N_SRC-1:0]        elig,
    input  logic [N_SRC*MODE_W-1:0] mode_bus,
    output logic                    any,
    output logic [ID_W-1:0]         id,
    output logic [MODE_W-1:0]       mode
);

    // Scan from the highest index downward so the lowest set index is the
    // last assignment and therefore wins.
    always_comb begin
        any  = 1'b0;
        id   = '0;
        mode = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any  = 1'b1;
                id   = ID_W'(i);
                mode = mode_bus[i*MODE_W +: MODE_W];
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-captured, maskable, fixed-priority interrupt sequencer with irq/int_ack/eoi handshake.
// Latency: request line first sampled high at edge k -> pending at k -> irq=1 after edge k+1.
// Backpressure: one request presented at a time; later events wait in pending until eoi.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   irq_in       raw level request lines (rising edge = new event)
//   mode_bus     per-source mode codes, source i at [i*MODE_W +: MODE_W]
//   en_int       global interrupt enable
//   mask_we/mask_wdata  mask register write (1 = masked)
//   int_ack/eoi  CPU accept and end-of-interrupt pulses
//   irq, irq_id, irq_mode  registered request, source index and mode to the CPU
//   busy         handler in service
//   pending/mask status readback
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int N_SRC  = INTC_N_SRC,
    parameter int MODE_W = INTC_MODE_W,
    parameter int ID_W   = intc_id_w(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        irq_in,
    input  logic [N_SRC*MODE_W-1:0] mode_bus,
    input  logic                    en_int,
    input  logic                    mask_we,
    input  logic [N_SRC-1:0]        mask_wdata,
    input  logic                    int_ack,
    input  logic                    eoi,
    output logic                    irq,
    output logic [ID_W-1:0]         irq_id,
    output logic [MODE_W-1:0]       irq_mode,
    output logic                    busy,
    output logic [N_SRC-1:0]        pending,
    output logic [N_SRC-1:0]        mask
);

    intc_state_t        state;
    logic [N_SRC-1:0]   irq_d;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   ack_clr;
    logic [N_SRC-1:0]   elig;
    logic               pick_any;
    logic [ID_W-1:0]    pick_id;
    logic [MODE_W-1:0]  pick_mode;

    assign rise = irq_in & ~irq_d;
    assign elig = pending & ~mask;

    // Accepting a request retires its pending bit.
    always_comb begin
        ack_clr = '0;
        if (state == ST_REQ && int_ack) begin
            ack_clr[irq_id] = 1'b1;
        end
    end

    int_priority_pick #(
        .N_SRC  (N_SRC),
        .MODE_W (MODE_W),
        .ID_W   (ID_W)
    ) u_pick (
        .elig     (elig),
        .mode_bus (mode_bus),
        .any      (pick_any),
        .id       (pick_id),
        .mode     (pick_mode)
    );

    // Edge detect, pending and mask. A new edge beats a same-cycle clear so
    // an event arriving during the ack is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_d   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_d   <= irq_in;
            pending <= (pending & ~ack_clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // Sequencer. The presented id/mode are frozen once in REQ so the CPU
    // never sees the request change under it; no preemption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            irq      <= 1'b0;
            irq_id   <= '0;
            irq_mode <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_int && pick_any) begin
                        state    <= ST_REQ;
                        irq      <= 1'b1;
                        irq_id   <= pick_id;
                        irq_mode <= pick_mode;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state <= ST_SVC;
                        irq   <= 1'b0;
                        busy  <= 1'b1;
                    end else if (!en_int || mask[irq_id]) begin
                        // Withdraw; the source stays pending for later.
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                    end
                end
                ST_SVC: begin
                    if (eoi) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    irq      <= 1'b0;
                    irq_id   <= '0;
                    irq_mode <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
`timescale 1ns/1ps
module tb_interrupt_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_in;
    logic [11:0] mode_bus;
    logic        en_int;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        int_ack;
    logic        eoi;
    logic        irq;
    logic [1:0]  irq_id;
    logic [2:0]  irq_mode;
    logic        busy;
    logic [3:0]  pending;
    logic [3:0]  mask;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mode_bus   (mode_bus),
        .en_int     (en_int),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .irq        (irq),
        .irq_id     (irq_id),
        .irq_mode   (irq_mode),
        .busy       (busy),
        .pending    (pending),
        .mask       (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are read 1ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; en_int = 1'b1; mask_we = 1'b0; mask_wdata = '0;
        int_ack = 1'b0; eoi = 1'b0;
        // src3=3, src2=5, src1=6, src0=2
        mode_bus = {3'b011, 3'b101, 3'b110, 3'b010};
        tick(2);
        checks++;
        if ({irq, irq_id, irq_mode, busy, pending, mask} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got irq=%b id=%0d mode=%0d busy=%b pend=%b mask=%b want all 0",
                     irq, irq_id, irq_mode, busy, pending, mask);
        end
        rst = 1'b0;
        tick();
        // int_ack while idle is ignored
        pulse_ack();
        checks++;
        if (busy !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack got busy=%b irq=%b want 0 0", busy, irq);
        end
    endtask

    task automatic test_single();
        irq_in[2] = 1'b1;
        tick();
        checks++;
        if (pending !== 4'b0100 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_capture got pend=%b irq=%b want 0100 0", pending, irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd2 || irq_mode !== 3'd5) begin
            errors++;
            $display("FAIL single_irq got irq=%b id=%0d mode=%0d want 1 2 5", irq, irq_id, irq_mode);
        end
        pulse_ack();
        checks++;
        if (busy !== 1'b1 || pending[2] !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got busy=%b pend=%b irq=%b want 1 0000 0", busy, pending, irq);
        end
        pulse_eoi();
        tick();
        checks++;
        if (busy !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_eoi got busy=%b irq=%b want 0 0", busy, irq);
        end
        irq_in = '0;
        tick();
    endtask

    task automatic test_priority();
        irq_in = 4'b1010;
        tick(2);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd1 || irq_mode !== 3'd6) begin
            errors++;
            $display("FAIL prio_first got irq=%b id=%0d mode=%0d want 1 1 6", irq, irq_id, irq_mode);
        end
        pulse_ack();
        pulse_eoi();
        checks++;
        if (irq !== 1'b0 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL prio_gap got irq=%b pend=%b want 0 1000", irq, pending);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd3 || irq_mode !== 3'd3) begin
            errors++;
            $display("FAIL prio_second got irq=%b id=%0d mode=%0d want 1 3 3", irq, irq_id, irq_mode);
        end
        pulse_ack();
        pulse_eoi();
        irq_in = '0;
        tick();
    endtask

    task automatic test_mask_enable();
        mask_we = 1'b1; mask_wdata = 4'b0001;
        tick();
        mask_we = 1'b0;
        irq_in[0] = 1'b1;
        tick(2);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0001 || mask !== 4'b0001) begin
            errors++;
            $display("FAIL masked got irq=%b pend=%b mask=%b want 0 0001 0001", irq, pending, mask);
        end
        mask_we = 1'b1; mask_wdata = 4'b0000;
        tick();
        mask_we = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL unmask got irq=%b id=%0d want 1 0", irq, irq_id);
        end
        en_int = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0 || pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL withdraw got irq=%b pend=%b want 0 xxx1", irq, pending);
        end
        en_int = 1'b1;
        tick();
        pulse_ack();
        pulse_eoi();
        irq_in = '0;
        tick();
    endtask

    task automatic test_no_preempt();
        irq_in[2] = 1'b1;
        tick(2);
        irq_in[0] = 1'b1;
        tick(2);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b0101) begin
            errors++;
            $display("FAIL no_preempt got irq=%b id=%0d pend=%b want 1 2 0101", irq, irq_id, pending);
        end
        // eoi while still in REQ is ignored
        pulse_eoi();
        checks++;
        if (irq !== 1'b1 || busy !== 1'b0 || irq_id !== 2'd2) begin
            errors++;
            $display("FAIL stray_eoi got irq=%b busy=%b id=%0d want 1 0 2", irq, busy, irq_id);
        end
        pulse_ack();
        checks++;
        if (busy !== 1'b1 || irq_id !== 2'd2) begin
            errors++;
            $display("FAIL preempt_svc got busy=%b id=%0d want 1 2", busy, irq_id);
        end
        pulse_eoi();
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0 || irq_mode !== 3'd2) begin
            errors++;
            $display("FAIL preempt_next got irq=%b id=%0d mode=%0d want 1 0 2", irq, irq_id, irq_mode);
        end
        pulse_ack();
        pulse_eoi();
        irq_in = '0;
        tick();
    endtask

    task automatic test_rearm_set_wins();
        irq_in[1] = 1'b1;
        tick(2);
        pulse_ack();
        pulse_eoi();
        tick(3);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL level_once got irq=%b pend=%b want 0 0000", irq, pending);
        end
        irq_in[1] = 1'b0;
        tick();
        irq_in[1] = 1'b1;
        tick(2);
        irq_in[1] = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL rearm got irq=%b id=%0d want 1 1", irq, irq_id);
        end
        irq_in[1] = 1'b1;
        pulse_ack();
        checks++;
        if (pending[1] !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got pend=%b busy=%b want 0010 1", pending, busy);
        end
        pulse_eoi();
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL set_wins_next got irq=%b id=%0d want 1 1", irq, irq_id);
        end
        pulse_ack();
        pulse_eoi();
        irq_in = '0;
        tick();
    endtask

    task automatic test_async_reset();
        mask_we = 1'b1; mask_wdata = 4'b0100;
        tick();
        mask_we = 1'b0;
        irq_in[0] = 1'b1;
        tick(2);
        pulse_ack();
        irq_in = 4'b1011;
        tick();
        checks++;
        if (pending !== 4'b1010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got pend=%b busy=%b want 1010 1", pending, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({irq, irq_id, irq_mode, busy, pending, mask} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset got irq=%b id=%0d mode=%0d busy=%b pend=%b mask=%b want all 0",
                     irq, irq_id, irq_mode, busy, pending, mask);
        end
        irq_in = '0;
        tick();
        rst = 1'b0;
        tick(4);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset got irq=%b pend=%b want 0 0000", irq, pending);
        end
        irq_in[3] = 1'b1;
        tick(2);
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd3) begin
            errors++;
            $display("FAIL post_reset_edge got irq=%b id=%0d want 1 3", irq, irq_id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask_enable();
        test_no_preempt();
        test_rearm_set_wins();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
